// File: rtl/rv32_hart_pc_sched.sv
// rv32_hart_pc_sched: per-hart PC registers with round-robin issue and in-flight blocking for a barrel pipeline
module rv32_hart_pc_sched #(
  parameter int NUM_HARTS = 8,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] HART_PC_STRIDE = '0
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_HARTS-1:0]         hart_en,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [$clog2(NUM_HARTS)-1:0] fetch_hart,
  output logic [PC_W-1:0]              fetch_pc,
  input  logic                         res_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] res_hart,
  input  logic                         res_has_new_pc,
  input  logic [PC_W-1:0]              res_next_pc,
  output logic [NUM_HARTS-1:0]         inflight_mask,
  output logic                         err
);
  localparam int HW = $clog2(NUM_HARTS);
  logic [PC_W-1:0] pc [NUM_HARTS];
  logic [NUM_HARTS-1:0] inflight, elig;
  logic [HW-1:0] rr_ptr, cand, idx;
  logic found, issue, res_ok, in_range;
  assign elig = hart_en & ~inflight;
  always_comb begin
    found = 1'b0;
    cand = '0;
    idx = '0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      idx = rr_ptr + HW'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        cand = idx;
      end
    end
  end
  assign fetch_valid = found;
  assign fetch_hart = found ? cand : '0;
  assign fetch_pc = found ? pc[cand] : '0;
  assign inflight_mask = inflight;
  assign issue = found & fetch_ready;
  assign in_range = {1'b0, res_hart} < (HW+1)'(NUM_HARTS);
  // only an in-flight hart may be resolved; anything else is a protocol error
  assign res_ok = res_valid & in_range & inflight[res_hart];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARTS; i++) pc[i] <= RESET_PC + PC_W'(i) * HART_PC_STRIDE;
      inflight <= '0;
      rr_ptr <= '0;
      err <= 1'b0;
    end else begin
      if (issue) begin
        inflight[cand] <= 1'b1;
        rr_ptr <= cand + HW'(1);
      end
      if (res_ok) begin
        inflight[res_hart] <= 1'b0;
        pc[res_hart] <= res_has_new_pc ? {res_next_pc[PC_W-1:2], 2'b00} : pc[res_hart] + PC_W'(4);
      end
      if (res_valid && (!res_ok || (res_has_new_pc && |res_next_pc[1:0]))) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rv32_hart_pc_sched.sv
// tb_rv32_hart_pc_sched: directed and randomized checks of the hart PC sequencer against a behavioural model
module tb_rv32_hart_pc_sched;
  logic clk = 0, rst = 1;
  logic [7:0] hart_en = '0;
  logic fetch_valid, fetch_ready = 0;
  logic [2:0] fetch_hart;
  logic [31:0] fetch_pc;
  logic res_valid = 0, res_has_new_pc = 0;
  logic [2:0] res_hart = '0;
  logic [31:0] res_next_pc = '0;
  logic [7:0] inflight_mask;
  logic err;
  int checks = 0, errors = 0;
  logic [31:0] m_pc [8];
  logic [7:0] m_inf;
  int m_rr;
  bit m_err;

  rv32_hart_pc_sched #(.NUM_HARTS(8), .PC_W(32), .RESET_PC(32'h0), .HART_PC_STRIDE(32'h100)) dut (
    .clk(clk), .rst(rst), .hart_en(hart_en), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_hart(fetch_hart), .fetch_pc(fetch_pc), .res_valid(res_valid), .res_hart(res_hart),
    .res_has_new_pc(res_has_new_pc), .res_next_pc(res_next_pc), .inflight_mask(inflight_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) m_pc[i] = i * 32'h100;
    m_inf = '0;
    m_rr = 0;
    m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    mreset();
    chk("rst_mask", inflight_mask, 8'h00);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 0;
  endtask

  // one clock: drive at negedge, compare to model, advance model across the edge
  task automatic cyc(input logic [7:0] en, input bit rdy, input bit rv, input int rh, input bit nw, input logic [31:0] np);
    bit ev;
    int eh, h;
    logic [7:0] old;
    hart_en = en;
    fetch_ready = rdy;
    res_valid = rv;
    res_hart = 3'(rh);
    res_has_new_pc = nw;
    res_next_pc = np;
    #1;
    ev = 0;
    eh = 0;
    for (int k = 0; k < 8; k++) begin
      h = (m_rr + k) % 8;
      if (!ev && en[h] && !m_inf[h]) begin
        ev = 1;
        eh = h;
      end
    end
    chk("valid", fetch_valid, ev);
    chk("hart", fetch_hart, ev ? eh : 0);
    chk("pc", fetch_pc, ev ? m_pc[eh] : 32'h0);
    chk("mask", inflight_mask, m_inf);
    chk("err", err, m_err);
    old = m_inf;
    if (rv) begin
      if (old[rh]) begin
        m_pc[rh] = nw ? (np & ~32'h3) : m_pc[rh] + 32'h4;
        m_inf[rh] = 0;
        if (nw && np[1:0] != 0) m_err = 1;
      end else m_err = 1;
    end
    if (ev && rdy) begin
      m_inf[eh] = 1;
      m_rr = (eh + 1) % 8;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [7:0] en, input bit rdy);
    cyc(en, rdy, 0, 0, 0, 0);
  endtask

  initial begin
    int rh, off;
    mreset();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) idle(8'hFF, 1);
    chk("all_inflight", inflight_mask, 8'hFF);
    cyc(8'hFF, 1, 1, 3, 0, 0);
    chk("h3_hart", fetch_hart, 3'd3);
    chk("h3_pc", fetch_pc, 32'h304);
    idle(8'hFF, 1);
    cyc(8'hFF, 1, 1, 5, 1, 32'h1234_5678);
    chk("h5_pc", fetch_pc, 32'h1234_5678);
    chk("h5_err0", err, 1'b0);
    idle(8'hFF, 1);
    cyc(8'hFF, 1, 1, 5, 1, 32'h1234_567A);
    chk("h5_pc_mis", fetch_pc, 32'h1234_5678);
    chk("h5_err1", err, 1'b1);
    do_reset();
    for (int i = 0; i < 9; i++) idle(8'h0F, i % 2 == 0);
    chk("en_mask", inflight_mask, 8'h0F);
    do_reset();
    cyc(8'h04, 0, 1, 2, 1, 32'hDEAD_BEE0);
    chk("rdy_res_pc", fetch_pc, 32'h200);
    for (int i = 0; i < 3; i++) idle(8'hFF, 0);
    chk("err_sticky", err, 1'b1);
    do_reset();
    idle(8'hFF, 1);
    idle(8'hFF, 1);
    cyc(8'hFF, 1, 1, 1, 1, 32'hFFFF_FFFC);
    idle(8'h02, 1);
    for (int i = 0; i < 3; i++) idle(8'hFF, 1);
    cyc(8'hFF, 1, 1, 1, 0, 0);
    idle(8'h02, 0);
    chk("wrap_pc", fetch_pc, 32'h0);
    chk("wrap_mask", inflight_mask, 8'h7D);
    idle(8'hFF, 1);
    do_reset();
    chk("post_rst_pc", fetch_pc, 32'h0);
    idle(8'hFF, 1);
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) do_reset();
      rh = 0;
      if ($urandom_range(15) == 0) rh = $urandom_range(7);
      else begin
        off = $urandom_range(7);
        rh = -1;
        for (int k = 0; k < 8; k++) if (rh < 0 && m_inf[(off + k) % 8]) rh = (off + k) % 8;
      end
      if (rh >= 0 && $urandom_range(1) == 1)
        cyc($urandom_range(3) == 0 ? 8'($urandom) : 8'hFF, $urandom_range(2) != 0, 1, rh,
            $urandom_range(1) == 1, $urandom_range(31) == 0 ? $urandom : ($urandom & ~32'h3));
      else
        idle($urandom_range(3) == 0 ? 8'($urandom) : 8'hFF, $urandom_range(2) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
